// File: rtl/bcd_add4.sv
// Registered packed-BCD adder: sum = a + b + c_in with decimal carry out.
// A ripple chain of per-digit BCD adders feeds a single output register stage.
module bcd_add4 #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  c_in,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  c_out
);

  localparam int unsigned W = 4 * DIGITS;

  logic [W-1:0] sum_c;
  logic         carry_c;

  // Per-digit decimal correction: any raw digit sum above 9 (including non-BCD
  // inputs) gets +6 and produces a carry into the next digit.
  always_comb begin
    logic [4:0] t;
    logic       cy;
    sum_c = '0;
    t     = '0;
    cy    = c_in;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      t = 5'(a[4*i +: 4]) + 5'(b[4*i +: 4]) + 5'(cy);
      if (t > 5'd9) begin
        sum_c[4*i +: 4] = 4'(t + 5'd6);
        cy              = 1'b1;
      end else begin
        sum_c[4*i +: 4] = t[3:0];
        cy              = 1'b0;
      end
    end
    carry_c = cy;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sum   <= '0;
      c_out <= 1'b0;
    end else begin
      sum   <= sum_c;
      c_out <= carry_c;
    end
  end

endmodule

// File: tb/tb_bcd_add4.sv
// Self-checking bench for bcd_add4: decimal reference model checked every cycle,
// plus hand-computed literal expectations and randomized operands.
module tb_bcd_add4;

  logic        sys_clk;
  logic        sys_rst_n;
  logic [15:0] a;
  logic [15:0] b;
  logic        c_in;
  logic [15:0] sum;
  logic        c_out;

  int n_checks = 0;
  int n_fails  = 0;

  logic [16:0] exp_out;
  logic        lit_valid = 1'b0;
  logic [16:0] lit_exp   = '0;
  string       lit_name  = "";
  event        chk_ev;

  bcd_add4 #(.DIGITS(4)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .a        (a),
    .b        (b),
    .c_in     (c_in),
    .sum      (sum),
    .c_out    (c_out)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  function automatic int nib(logic [15:0] v, int d);
    logic [15:0] tmp;
    tmp = v >> (4 * d);
    return int'(tmp[3:0]);
  endfunction

  function automatic int bcd2int(logic [15:0] v);
    int r = 0;
    for (int d = 3; d >= 0; d--) r = r * 10 + nib(v, d);
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(int n);
    logic [15:0] r = '0;
    int m = n;
    for (int d = 0; d < 4; d++) begin
      r = r | (16'(m % 10) << (4 * d));
      m = m / 10;
    end
    return r;
  endfunction

  // Valid BCD operands: plain decimal arithmetic modulo 10^4.
  // Otherwise the per-digit "above 9 gets +6 and carries" rule on integers.
  function automatic logic [16:0] ref_add(logic [15:0] x, logic [15:0] y, logic ci);
    bit          valid;
    int          s;
    int          cy;
    int          t;
    logic [15:0] r;
    valid = 1'b1;
    for (int d = 0; d < 4; d++)
      if (nib(x, d) > 9 || nib(y, d) > 9) valid = 1'b0;
    if (valid) begin
      s = bcd2int(x) + bcd2int(y) + int'(ci);
      return {s >= 10000, int2bcd(s % 10000)};
    end
    cy = int'(ci);
    r  = '0;
    for (int d = 0; d < 4; d++) begin
      t = nib(x, d) + nib(y, d) + cy;
      if (t > 9) begin
        r  = r | (16'((t + 6) % 16) << (4 * d));
        cy = 1;
      end else begin
        r  = r | (16'(t) << (4 * d));
        cy = 0;
      end
    end
    return {cy != 0, r};
  endfunction

  function automatic logic [15:0] rand_op(bit bcd_only);
    logic [15:0] r = '0;
    for (int d = 0; d < 4; d++)
      r = r | (16'(bcd_only ? $urandom_range(0, 9) : $urandom_range(0, 15)) << (4 * d));
    return r;
  endfunction

  // Expected registered output, one cycle behind the sampled inputs.
  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) exp_out <= '0;
    else            exp_out <= ref_add(a, b, c_in);
  end

  // Single compare process: model every cycle, literal expectations when posted.
  always @(negedge sys_clk or chk_ev) begin
    n_checks++;
    if ({c_out, sum} !== exp_out) begin
      n_fails++;
      $display("FAIL model: got sum=%h c_out=%b, want sum=%h c_out=%b at %0t",
               sum, c_out, exp_out[15:0], exp_out[16], $time);
    end
    if (lit_valid) begin
      n_checks++;
      if ({c_out, sum} !== lit_exp) begin
        n_fails++;
        $display("FAIL %s: got sum=%h c_out=%b, want sum=%h c_out=%b at %0t",
                 lit_name, sum, c_out, lit_exp[15:0], lit_exp[16], $time);
      end
    end
  end

  task automatic expect_lit(string name, logic [15:0] s, logic c);
    lit_name  = name;
    lit_exp   = {c, s};
    lit_valid = 1'b1;
    @(negedge sys_clk);
    #1;
    lit_valid = 1'b0;
  endtask

  task automatic check_now(string name, logic [15:0] s, logic c);
    lit_name  = name;
    lit_exp   = {c, s};
    lit_valid = 1'b1;
    -> chk_ev;
    #1;
    lit_valid = 1'b0;
  endtask

  task automatic drive(logic [15:0] x, logic [15:0] y, logic ci);
    a    = x;
    b    = y;
    c_in = ci;
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    sys_rst_n = 1'b0;
    a         = 16'h1234;
    b         = 16'h5678;
    c_in      = 1'b0;
    repeat (3) expect_lit("reset_hold", 16'h0000, 1'b0);

    sys_rst_n = 1'b1;
    drive(16'h0000, 16'h0001, 1'b0);
    expect_lit("first_edge", 16'h0001, 1'b0);

    drive(16'h0009, 16'h0001, 1'b0);
    expect_lit("carry_d0", 16'h0010, 1'b0);
    drive(16'h0099, 16'h0001, 1'b0);
    expect_lit("carry_d1", 16'h0100, 1'b0);
    drive(16'h0999, 16'h0001, 1'b0);
    expect_lit("carry_d2", 16'h1000, 1'b0);
    drive(16'h9999, 16'h0001, 1'b0);
    expect_lit("wrap", 16'h0000, 1'b1);
    drive(16'h9999, 16'h9999, 1'b1);
    expect_lit("max_sum", 16'h9999, 1'b1);
    drive(16'h000A, 16'h0000, 1'b0);
    expect_lit("non_bcd_a", 16'h0010, 1'b0);
    drive(16'hFFFF, 16'hFFFF, 1'b1);
    expect_lit("non_bcd_f", 16'h5555, 1'b1);

    // No combinational path: new inputs must not show before the next edge.
    drive(16'h0000, 16'h0000, 1'b0);
    a    = 16'h1234;
    b    = 16'h5678;
    c_in = 1'b1;
    expect_lit("latency_hold", 16'h0000, 1'b0);
    @(posedge sys_clk);
    #1;
    expect_lit("latency_new", 16'h6913, 1'b0);

    // Feedback counter: a = previous sum, b = 1.
    drive(16'h0000, 16'h0001, 1'b0);
    for (int k = 1; k <= 100; k++) begin
      expect_lit("count", int2bcd(k), 1'b0);
      drive(sum, 16'h0001, 1'b0);
    end
    sys_rst_n = 1'b0;
    #1;
    check_now("reset_async", 16'h0000, 1'b0);
    expect_lit("reset_flush", 16'h0000, 1'b0);
    a         = 16'h4321;
    b         = 16'h1111;
    c_in      = 1'b0;
    sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;
    expect_lit("post_reset", 16'h5432, 1'b0);

    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        sys_rst_n = 1'b0;
        #1;
        check_now("reset_rand", 16'h0000, 1'b0);
        @(negedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
      end
      drive(rand_op($urandom_range(0, 3) != 0), rand_op($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)));
    end

    @(negedge sys_clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
